// File: rtl/ifetch_stage_if.sv
// Instruction-ROM fetch bus between the fetch stage (master) and a synchronous-read ROM (slave).
interface ifetch_stage_if;
  logic        en;
  logic [31:0] addr;
  logic [31:0] data;

  modport master (output en, output addr, input data);
  modport slave  (input en, input addr, output data);
endinterface

// File: rtl/ifetch_stage.sv
// RV32I instruction-fetch stage: PC, 1-cycle ROM fetch with stall skid buffer,
// not-taken prediction with EX redirects, and the IF/ID pipeline register.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_stage_if.master irom,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          id_valid,
  output logic [31:0]   id_inst,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_pc4,
  output logic [6:0]    id_opcode,
  output logic [2:0]    id_func3,
  output logic [6:0]    id_func7,
  output logic [15:0]   redirect_cnt
);

  logic [31:0] pc_r;
  logic        req_v_r;
  logic [31:0] req_pc_r;
  logic        skid_v_r;
  logic [31:0] skid_inst_r;
  logic [31:0] skid_pc_r;
  logic        id_valid_r;
  logic [31:0] id_inst_r;
  logic [31:0] id_pc_r;
  logic [31:0] id_pc4_r;
  logic [15:0] redirect_cnt_r;

  logic        fetch_en_s;
  logic [31:0] fetch_addr_s;
  logic [31:0] target_s;

  // Low address bits of the redirect target are dropped, never trapped.
  assign target_s = redirect_pc & ~32'h0000_0003;

  // Fetch request: reset suppresses it, a redirect fetches the target at once.
  always_comb begin
    fetch_en_s   = 1'b0;
    fetch_addr_s = pc_r;
    if (!rst_n) begin
      fetch_en_s = 1'b0;
    end else if (redirect) begin
      fetch_en_s   = 1'b1;
      fetch_addr_s = target_s;
    end else if (stall) begin
      fetch_en_s = 1'b0;
    end else begin
      fetch_en_s = 1'b1;
    end
  end

  // PC, in-flight tracking, skid buffer, IF/ID register and redirect counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r           <= RESET_PC & ~32'h0000_0003;
      req_v_r        <= 1'b0;
      req_pc_r       <= 32'h0000_0000;
      skid_v_r       <= 1'b0;
      skid_inst_r    <= NOP_INST;
      skid_pc_r      <= 32'h0000_0000;
      id_valid_r     <= 1'b0;
      id_inst_r      <= NOP_INST;
      id_pc_r        <= 32'h0000_0000;
      id_pc4_r       <= 32'h0000_0000;
      redirect_cnt_r <= 16'h0000;
    end else if (redirect) begin
      // Squash both the ID instruction and whatever is returning from the ROM.
      pc_r       <= target_s + 32'h0000_0004;
      req_v_r    <= 1'b1;
      req_pc_r   <= target_s;
      skid_v_r   <= 1'b0;
      id_valid_r <= 1'b0;
      id_inst_r  <= NOP_INST;
      if (redirect_cnt_r != 16'hFFFF) begin
        redirect_cnt_r <= redirect_cnt_r + 16'h0001;
      end else begin
        redirect_cnt_r <= redirect_cnt_r;
      end
    end else if (stall) begin
      if (req_v_r) begin
        skid_inst_r <= irom.data;
        skid_pc_r   <= req_pc_r;
        skid_v_r    <= 1'b1;
        req_v_r     <= 1'b0;
      end else begin
        skid_v_r <= skid_v_r;
      end
    end else begin
      if (skid_v_r) begin
        id_valid_r <= 1'b1;
        id_inst_r  <= skid_inst_r;
        id_pc_r    <= skid_pc_r;
        id_pc4_r   <= skid_pc_r + 32'h0000_0004;
      end else if (req_v_r) begin
        id_valid_r <= 1'b1;
        id_inst_r  <= irom.data;
        id_pc_r    <= req_pc_r;
        id_pc4_r   <= req_pc_r + 32'h0000_0004;
      end else begin
        id_valid_r <= 1'b0;
        id_inst_r  <= NOP_INST;
      end
      pc_r     <= pc_r + 32'h0000_0004;
      req_v_r  <= 1'b1;
      req_pc_r <= pc_r;
      skid_v_r <= 1'b0;
    end
  end

  assign irom.en      = fetch_en_s;
  assign irom.addr    = fetch_addr_s;
  assign id_valid     = id_valid_r;
  assign id_inst      = id_inst_r;
  assign id_pc        = id_pc_r;
  assign id_pc4       = id_pc4_r;
  assign id_opcode    = id_inst_r[6:0];
  assign id_func3     = id_inst_r[14:12];
  assign id_func7     = id_inst_r[31:25];
  assign redirect_cnt = redirect_cnt_r;

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined RV32I core. It owns the PC, issues addresses to a synchronous-read instruction ROM with 1-cycle latency, and buffers returned instructions across stalls. It presents the current ID instruction with its opcode/func3/func7 fields sliced out for the control decoder. It accepts stall requests from the hazard unit and taken-branch/jump redirects resolved in EX, predicts not-taken, and squashes wrong-path instructions.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0)

- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- irom_en  out  1  fetch request this cycle
- irom_addr  out  32  byte address of fetch; bits [1:0] always 0
- irom_data  in  32  instruction for the address issued in the previous cycle
- stall  in  1  hold IF/ID and PC (load-use hazard)
- redirect  in  1  EX resolved taken branch / jal / jalr
- redirect_pc  in  32  redirect target
- id_valid  out  1  IF/ID holds a real instruction
- id_inst  out  32  IF/ID instruction
- id_pc  out  32  PC of id_inst
- id_pc4  out  32  id_pc + 4 (rd source for jal/jalr)
- id_opcode  out  7  id_inst[6:0]
- id_func3  out  3  id_inst[14:12]
- id_func7  out  7  id_inst[31:25]
- redirect_cnt  out  16  redirect events since reset, saturating

## Operation
- State: pc_q (next address to issue), req_v/req_pc (fetch in flight), skid_v/skid_inst/skid_pc (returned instruction held during stall), the IF/ID register, and redirect_cnt.
- Per-cycle priority: reset > redirect > stall > normal.
- Reset (rst_n=0 at edge): pc_q=RESET_PC, req_v=0, skid_v=0, id_valid=0, id_inst=NOP_INST, id_pc=0, id_pc4=0, redirect_cnt=0. While rst_n=0, irom_en=0 combinationally.
- Redirect (overrides stall):
  - irom_en=1 and irom_addr={redirect_pc[31:2],2'b00} in the same cycle.
  - pc_q<=target+4, req_v<=1, req_pc<=target.
  - IF/ID<=bubble (id_valid=0, id_inst=NOP_INST, id_pc/id_pc4 unchanged). skid_v<=0. Current irom_data discarded.
  - redirect_cnt += 1, saturating at 16'hFFFF.
- Stall (no redirect):
  - irom_en=0, pc_q holds, IF/ID holds.
  - If req_v: skid_inst<=irom_data, skid_pc<=req_pc, skid_v<=1, req_v<=0.
- Normal:
  - IF/ID source: skid if skid_v; else irom_data/req_pc if req_v; else bubble.
  - Issue: irom_en=1, irom_addr=pc_q, req_pc<=pc_q, req_v<=1, pc_q<=pc_q+4. skid_v<=0.
- skid_v and req_v are never both 1.
- Ordering: instructions leave through IF/ID in strict PC order except across a redirect.
- Arithmetic:
  - pc+4 and id_pc4 wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
  - redirect_pc[1:0] are ignored; no misalignment trap.
- id_opcode/id_func3/id_func7 are pure slices of id_inst. A bubble therefore decodes as addi x0.

## Timing
- Fetch latency: address issued in cycle n, data returns in n+1, captured at the end of n+1, visible in ID in n+2.
- First fetch: issued in the first cycle with rst_n=1. RESET_PC reaches ID two cycles later.
- Redirect penalty: redirect in cycle n gives bubbles in ID during n+1. The target is in ID at n+2. The ID instruction and the in-flight fetch are both squashed.
- Stall of k cycles holds ID for k cycles. After release, ID advances every cycle with no extra bubble, because the skid supplies the next instruction while the new fetch is in flight.
- Redirect coincident with stall: redirect wins and the stall is ignored for the fetch path.
- Reset mid-operation discards the skid, the in-flight fetch and IF/ID. It has the same visible effect as power-on reset.

## Test plan
- Reset with RESET_PC=32'h80 and ROM word i = i, no stall/redirect -> irom_addr 80,84,88…; id_valid rises 2 cycles after reset release; id_pc 80,84,88 with id_inst 0x20,0x21,0x22; id_pc4=id_pc+4.
- Steady stream, stall high 3 cycles while id_pc=84 -> id_pc stays 84 for 3 cycles, irom_en=0 during the stall, then 88,8C consecutively with no bubble and no duplicate or skip.
- Redirect to 32'h200 while id_pc=90 -> next cycle id_valid=0 and id_inst=0x13; following cycle id_pc=200; redirect_cnt=1; irom_addr=200 in the redirect cycle.
- Redirect to 32'h303 asserted together with stall -> irom_addr=300, stall ignored, id_pc=300 two cycles later, no skid instruction leaks out.
- RESET_PC=32'hFFFF_FFF8 -> id_pc FFFFFFF8, FFFFFFFC, 00000000; id_pc4 of FFFFFFFC = 0.
- Reset pulsed mid-stream with a stall active and skid full -> id_valid=0, redirect_cnt=0; fetch restarts at RESET_PC; the skid instruction never appears.
